// File: rtl/vram_scheduler.sv
`default_nettype none
// ============================================================================
// vram_scheduler : frame sequencer sharing the tile/sprite RAM between the
//                  display fetch and two writer clients.  Revision 1.0
// ============================================================================
module vram_scheduler #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int WINDOW = 68000
) (
   input  logic              clock_50,
   input  logic              reset_n,
   input  logic              sof,
   input  logic              eof,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_rvalid,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              we0,
   input  logic              we1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] cl_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              frame_tick,
   output logic [15:0]       frame_count,
   output logic              overrun,
   input  logic              overrun_clr
);

   localparam int               CNT_W    = $clog2(WINDOW + 1);
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

   typedef enum logic [1:0] {
      DISPLAY = 2'd0,
      TICK    = 2'd1,
      UPDATE  = 2'd2,
      CLOSE   = 2'd3
   } state_t;

   state_t           state;
   logic             last;
   logic [CNT_W-1:0] win_cnt;
   logic             grant_ok;
   logic             any_req;
   logic             pick0;
   logic             pick1;

   // An incoming sof closes the window immediately, so it also vetoes this cycle's grant.
   always_comb begin
      grant_ok  = (state == UPDATE) && !sof;
      any_req   = req0 | req1;
      pick0     = req0 && (!req1 || last);
      pick1     = req1 && (!req0 || !last);
      gnt0      = grant_ok && pick0;
      gnt1      = grant_ok && pick1;
      mem_addr  = disp_addr;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (gnt0) begin
         mem_addr  = addr0;
         mem_wdata = wdata0;
         mem_we    = we0;
      end else if (gnt1) begin
         mem_addr  = addr1;
         mem_wdata = wdata1;
         mem_we    = we1;
      end
   end

   assign disp_rdata = mem_rdata;
   assign cl_rdata   = mem_rdata;

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         state       <= DISPLAY;
         last        <= 1'b1;
         win_cnt     <= '0;
         frame_tick  <= 1'b0;
         frame_count <= 16'd0;
         overrun     <= 1'b0;
         disp_rvalid <= 1'b0;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
      end else begin
         disp_rvalid <= (state == DISPLAY) || (state == TICK);
         rvalid0     <= gnt0 && !we0;
         rvalid1     <= gnt1 && !we1;
         frame_tick  <= 1'b0;
         frame_count <= frame_count + {15'd0, state == TICK};
         if (gnt0) begin
            last <= 1'b0;
         end else if (gnt1) begin
            last <= 1'b1;
         end
         // A set from the state logic below overrides this clear.
         if (overrun_clr) begin
            overrun <= 1'b0;
         end
         case (state)
            DISPLAY: begin
               if (eof) begin
                  state      <= TICK;
                  frame_tick <= 1'b1;
               end
            end
            TICK: begin
               win_cnt <= '0;
               state   <= UPDATE;
            end
            UPDATE: begin
               win_cnt <= win_cnt + CNT_W'(1);
               if (sof) begin
                  state <= DISPLAY;
                  if (any_req) begin
                     overrun <= 1'b1;
                  end
               end else if (win_cnt == WIN_LAST) begin
                  state <= CLOSE;
               end
            end
            CLOSE: begin
               state <= DISPLAY;
               if (any_req) begin
                  overrun <= 1'b1;
               end
            end
            default: state <= DISPLAY;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vram_scheduler.sv
`default_nettype none
// tb_vram_scheduler : directed and randomized checks against a frame-phase
//                     reference model with a behavioural RAM.
module tb_vram_scheduler;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;
   localparam int WINDOW = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clock_50    = 1'b0;
   logic              reset_n     = 1'b0;
   logic              sof         = 1'b0;
   logic              eof         = 1'b0;
   logic              req0        = 1'b0;
   logic              req1        = 1'b0;
   logic              we0         = 1'b0;
   logic              we1         = 1'b0;
   logic              overrun_clr = 1'b0;
   logic [ADDR_W-1:0] disp_addr   = '0;
   logic [ADDR_W-1:0] addr0       = '0;
   logic [ADDR_W-1:0] addr1       = '0;
   logic [DATA_W-1:0] wdata0      = '0;
   logic [DATA_W-1:0] wdata1      = '0;
   logic [DATA_W-1:0] mem_rdata   = '0;

   logic [DATA_W-1:0] disp_rdata;
   logic              disp_rvalid;
   logic              gnt0;
   logic              gnt1;
   logic              rvalid0;
   logic              rvalid1;
   logic [DATA_W-1:0] cl_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              frame_tick;
   logic [15:0]       frame_count;
   logic              overrun;

   vram_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WINDOW(WINDOW)) dut (
      .clock_50(clock_50), .reset_n(reset_n), .sof(sof), .eof(eof),
      .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .cl_rdata(cl_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata), .frame_tick(frame_tick),
      .frame_count(frame_count), .overrun(overrun), .overrun_clr(overrun_clr)
   );

   always #10 clock_50 = ~clock_50;

   function automatic logic [DATA_W-1:0] pattern(input int i);
      return (i == 'h123) ? 8'h5A : DATA_W'(i * 7 + 3);
   endfunction

   // Behavioural single-port RAM, 1-cycle read latency, reloaded while in reset.
   logic [DATA_W-1:0] ram [0:DEPTH-1];
   always @(posedge clock_50) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= pattern(i);
      end else begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   // Reference model: m_blank = in vertical blank; m_cyc = 0 tick, 1..WINDOW update, WINDOW+1 close.
   logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
   bit                m_blank, m_last, m_ovr, m_tick, m_rv0, m_rv1, m_drv, m_drv_chk;
   int                m_cyc;
   logic [15:0]       m_fc;
   logic [DATA_W-1:0] m_rdata;
   bit                last_g0, last_g1, obs_g0, obs_g1;
   int                n_gnt0;
   int                checks = 0;
   int                errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_blank = 0; m_cyc = 0; m_last = 1; m_ovr = 0; m_tick = 0;
      m_rv0 = 0; m_rv1 = 0; m_drv = 0; m_drv_chk = 1; m_fc = 16'd0; m_rdata = '0;
      last_g0 = 0; last_g1 = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = pattern(i);
   endtask

   // One clock: check at the falling edge, advance the model, return at posedge+1.
   task automatic step();
      bit                in_upd, g0, g1, ovr_set;
      logic [ADDR_W-1:0] a;
      @(negedge clock_50);
      in_upd = m_blank && (m_cyc >= 1) && (m_cyc <= WINDOW);
      g0 = in_upd && !sof && req0 && (!req1 || m_last);
      g1 = in_upd && !sof && req1 && (!req0 || !m_last);
      obs_g0 = gnt0; obs_g1 = gnt1;
      if (gnt0) n_gnt0++;
      check("gnt0", gnt0, g0);
      check("gnt1", gnt1, g1);
      check("mem_we", mem_we, g0 ? we0 : (g1 ? we1 : 1'b0));
      check("mem_addr", mem_addr, g0 ? addr0 : (g1 ? addr1 : disp_addr));
      if (g0 || g1) check("mem_wdata", mem_wdata, g0 ? wdata0 : wdata1);
      check("frame_tick", frame_tick, m_tick);
      check("frame_count", frame_count, m_fc);
      check("overrun", overrun, m_ovr);
      check("rvalid0", rvalid0, m_rv0);
      check("rvalid1", rvalid1, m_rv1);
      if (m_rv0 || m_rv1) check("cl_rdata", cl_rdata, m_rdata);
      if (m_drv_chk) check("disp_rvalid", disp_rvalid, m_drv);

      m_rv0 = g0 && !we0;
      m_rv1 = g1 && !we1;
      if (g0 || g1) begin
         a = g0 ? addr0 : addr1;
         m_rdata = ref_mem[a];
         if (g0 && we0) ref_mem[a] = wdata0;
         if (g1 && we1) ref_mem[a] = wdata1;
      end
      m_drv     = !m_blank;
      m_drv_chk = !(m_blank && m_cyc == 0);
      m_tick    = !m_blank && eof;
      if (m_blank && m_cyc == 0) m_fc = m_fc + 16'd1;
      ovr_set = (req0 || req1) && ((in_upd && sof) || (m_blank && m_cyc == WINDOW + 1));
      if (ovr_set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      if (g0) m_last = 0;
      if (g1) m_last = 1;
      if (!m_blank) begin
         if (eof) begin m_blank = 1; m_cyc = 0; end
      end else if (m_cyc == 0) begin
         m_cyc = 1;
      end else if (m_cyc <= WINDOW) begin
         if (sof) m_blank = 0;
         else m_cyc++;
      end else begin
         m_blank = 0;
      end
      last_g0 = g0; last_g1 = g1;
      @(posedge clock_50);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // Asynchronous reset asserted mid-cycle; grants must collapse at once.
   task automatic apply_reset();
      reset_n = 1'b0;
      #1;
      check("rst_gnt0", gnt0, 1'b0);
      check("rst_gnt1", gnt1, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_frame_count", frame_count, 16'd0);
      @(posedge clock_50);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic start_blank();
      eof = 1; step(); eof = 0;
      step();
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clock_50);
      #1;
      reset_n = 1'b1;
      check("reset_frame_count", frame_count, 16'd0);
      check("reset_overrun", overrun, 1'b0);
      check("reset_frame_tick", frame_tick, 1'b0);
      run(3);

      // Frame tick and frame counting
      eof = 1; step(); eof = 0;
      check("tick_high", frame_tick, 1'b1);
      step();
      check("tick_one_cycle", frame_tick, 1'b0);
      check("count_first", frame_count, 16'd1);
      sof = 1; step(); sof = 0;
      for (int f = 0; f < 9; f++) begin
         start_blank();
         sof = 1; step(); sof = 0;
         step();
      end
      check("count_ten", frame_count, 16'd10);

      // Both clients requesting: alternation starting with client 0
      start_blank();
      req0 = 1; req1 = 1; we0 = 1; we1 = 0;
      addr0 = 12'h010; addr1 = 12'h020; wdata0 = 8'h11; wdata1 = 8'h22;
      step();
      check("rr_first_client0", obs_g0, 1'b1);
      step();
      check("rr_second_client1", obs_g1, 1'b1);
      run(2);
      req0 = 0; req1 = 0;
      run(6);

      // Client 0 read of 0x123
      start_blank();
      req0 = 1; we0 = 0; addr0 = 12'h123;
      step();
      req0 = 0;
      check("read_rvalid0", rvalid0, 1'b1);
      check("read_data", cl_rdata, 8'h5A);
      check("read_disp_rvalid", disp_rvalid, 1'b0);
      sof = 1; step(); sof = 0;
      step();

      // Window expiry with client 0 holding its request
      start_blank();
      n_gnt0 = 0;
      req0 = 1; we0 = 1; addr0 = 12'h040; wdata0 = 8'h44;
      run(WINDOW);
      check("window_grants", n_gnt0, WINDOW);
      step();
      check("close_overrun", overrun, 1'b1);
      req0 = 0; overrun_clr = 1; step(); overrun_clr = 0;
      check("overrun_cleared", overrun, 1'b0);

      // sof in the third update cycle with client 1 requesting
      start_blank();
      req1 = 1; we1 = 1; addr1 = 12'h050; wdata1 = 8'h55;
      run(2);
      sof = 1; step(); sof = 0;
      check("sof_gnt1", obs_g1, 1'b0);
      check("sof_overrun", overrun, 1'b1);
      disp_addr = 12'h3AB;
      step();
      req1 = 0; overrun_clr = 1; step(); overrun_clr = 0;

      // frame_count wrap
      force dut.frame_count = 16'hFFFF;
      m_fc = 16'hFFFF;
      step();
      release dut.frame_count;
      start_blank();
      check("count_wrap", frame_count, 16'd0);
      sof = 1; step(); sof = 0;
      step();

      // Reset in the middle of an update window
      start_blank();
      req0 = 1; we0 = 1; addr0 = 12'h060;
      step();
      apply_reset();
      req0 = 0;
      run(2);

      // Randomized traffic with well-behaved clients
      for (int c = 0; c < 4000; c++) begin
         if (!req0 || last_g0) begin
            req0 = ($urandom_range(0, 2) != 0); we0 = 1'($urandom_range(0, 1));
            addr0 = ADDR_W'($urandom_range(0, 63)); wdata0 = DATA_W'($urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            req0 = 0;
         end
         if (!req1 || last_g1) begin
            req1 = ($urandom_range(0, 2) != 0); we1 = 1'($urandom_range(0, 1));
            addr1 = ADDR_W'($urandom_range(0, 63)); wdata1 = DATA_W'($urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            req1 = 0;
         end
         eof = ($urandom_range(0, 19) == 0);
         sof = ($urandom_range(0, 9) == 0);
         overrun_clr = ($urandom_range(0, 7) == 0);
         disp_addr = ADDR_W'($urandom);
         if ($urandom_range(0, 999) == 0) apply_reset();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
